// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle spawner and its LFSR.
package obstacle_pkg;

  typedef enum logic [1:0] {
    TYPE_FLAT     = 2'b00,
    TYPE_TALL     = 2'b01,
    TYPE_FALL_TRI = 2'b10,
    TYPE_RISE_TRI = 2'b11
  } obs_type_t;

  typedef enum logic [1:0] {
    POS_TOP = 2'b00,
    POS_MID = 2'b01,
    POS_BOT = 2'b10
  } obs_pos_t;

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  // Biased x coordinates (screen x + 100).
  localparam logic [9:0]  PARK_X    = 10'd840;
  localparam logic [9:0]  SPAWN_X   = 10'd740;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Two random bits select a band; the unused code 11 folds onto the middle band.
  function automatic obs_pos_t pos_from_bits(input logic [1:0] bits);
    if (bits == 2'b11) return POS_MID;
    return obs_pos_t'(bits);
  endfunction

endpackage

// File: rtl/obstacle_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps on every clock in every game state.
module lfsr16
  import obstacle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  // Shift right, folding the tap mask in whenever a 1 falls out of bit 0.
  always_ff @(posedge clk) begin
    if (reset) q <= LFSR_SEED;
    else       q <= (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Spawns, scrolls and retires two obstacle slots once per video frame.
//
// Control pulses: frame_tick and start are single-cycle strobes sampled on
// the rising clk edge; game_over is a level sampled every cycle in RUN and
// wins over a coincident frame_tick. All outputs are registered and reflect
// a processed tick on the cycle after it was sampled.
module obstacle_spawner
  import obstacle_pkg::*;
#(
  parameter int BASE_SPEED    = 4,
  parameter int MAX_SPEED     = 12,
  parameter int SPEEDUP_EVERY = 8,
  parameter int MIN_GAP       = 40,
  parameter int FLICK_FRAMES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        game_over,
  output logic [1:0]  obs1_type,
  output logic [1:0]  obs2_type,
  output logic [1:0]  obs1_pos,
  output logic [1:0]  obs2_pos,
  output logic [9:0]  obs1_x,
  output logic [9:0]  obs2_x,
  output logic        flick1,
  output logic        flick2,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic        running,
  output logic [1:0]  fsm_state
);

  logic [15:0] lfsr;
  logic        lfsr_unused;
  state_t      state;
  logic [6:0]  gap;
  logic [6:0]  gap_load;
  logic [7:0]  ret_cnt;
  logic [8:0]  ret_sum;
  logic [1:0]  n_ret;
  logic [1:0]  act;
  logic [1:0]  retire;
  logic [1:0]  spawn_sel;
  logic        tick_run;
  logic        spawn_ok;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:10];
  assign fsm_state   = state;

  // A frame is processed only in RUN and only when no collision is flagged.
  assign tick_run     = (state == ST_RUN) && frame_tick && !game_over;
  // Spawn looks at occupancy before this tick, so a slot retiring now stays free.
  assign spawn_ok     = tick_run && (gap == 7'd0) && !(act[0] && act[1]);
  assign spawn_sel[0] = spawn_ok && !act[0];
  assign spawn_sel[1] = spawn_ok && act[0] && !act[1];
  assign gap_load     = 7'(MIN_GAP) + {1'b0, lfsr[9:4]};
  assign n_ret        = {1'b0, retire[0]} + {1'b0, retire[1]};
  assign ret_sum      = {1'b0, ret_cnt} + {7'd0, n_ret};

  // Game FSM: READY -> RUN on start, RUN -> HALT on game_over, HALT until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_READY;
      running <= 1'b0;
    end else begin
      case (state)
        ST_READY: if (start) begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        ST_RUN: if (game_over) begin
          state   <= ST_HALT;
          running <= 1'b0;
        end
        default: begin
          state   <= ST_HALT;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Frames-until-next-spawn counter, reloaded at game start and after each spawn.
  always_ff @(posedge clk) begin
    if (reset)                          gap <= 7'd0;
    else if (state == ST_READY && start) gap <= gap_load;
    else if (spawn_ok)                  gap <= gap_load;
    else if (tick_run && gap != 7'd0)   gap <= gap - 7'd1;
  end

  // Score and difficulty: every SPEEDUP_EVERY retirements add one px/frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      speed   <= 4'(BASE_SPEED);
      score   <= 16'd0;
      ret_cnt <= 8'd0;
    end else if (tick_run) begin
      score <= score + {14'd0, n_ret};
      if (ret_sum >= 9'(SPEEDUP_EVERY)) begin
        ret_cnt <= 8'(ret_sum - 9'(SPEEDUP_EVERY));
        if (speed < 4'(MAX_SPEED)) speed <= speed + 4'd1;
      end else begin
        ret_cnt <= ret_sum[7:0];
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    logic      act_q;
    obs_type_t type_q;
    obs_pos_t  pos_q;
    logic [9:0] x_q;
    logic      flick_q;
    logic [7:0] fcnt_q;

    assign act[i]    = act_q;
    assign retire[i] = tick_run && act_q && (x_q < {6'd0, speed});

    // One slot: park on reset/retire, load on spawn, else scroll and flicker.
    always_ff @(posedge clk) begin
      if (reset || retire[i]) begin
        act_q   <= 1'b0;
        type_q  <= TYPE_FLAT;
        pos_q   <= POS_TOP;
        x_q     <= PARK_X;
        flick_q <= 1'b0;
        fcnt_q  <= 8'd0;
      end else if (spawn_sel[i]) begin
        act_q   <= 1'b1;
        type_q  <= obs_type_t'(lfsr[1:0]);
        pos_q   <= pos_from_bits(lfsr[3:2]);
        x_q     <= SPAWN_X;
        flick_q <= 1'b0;
        fcnt_q  <= 8'd0;
      end else if (tick_run && act_q) begin
        x_q <= x_q - {6'd0, speed};
        if (fcnt_q == 8'(FLICK_FRAMES - 1)) begin
          fcnt_q  <= 8'd0;
          flick_q <= ~flick_q;
        end else begin
          fcnt_q <= fcnt_q + 8'd1;
        end
      end
    end
  end

  assign obs1_type = g_slot[0].type_q;
  assign obs1_pos  = g_slot[0].pos_q;
  assign obs1_x    = g_slot[0].x_q;
  assign flick1    = g_slot[0].flick_q;
  assign obs2_type = g_slot[1].type_q;
  assign obs2_pos  = g_slot[1].pos_q;
  assign obs2_x    = g_slot[1].x_q;
  assign flick2    = g_slot[1].flick_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed values.
module tb_obstacle_spawner;

  localparam int BASE_SPEED    = 4;
  localparam int MAX_SPEED     = 12;
  localparam int SPEEDUP_EVERY = 8;
  localparam int MIN_GAP       = 40;
  localparam int FLICK_FRAMES  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        game_over = 1'b0;
  logic [1:0]  obs1_type, obs2_type, obs1_pos, obs2_pos;
  logic [9:0]  obs1_x, obs2_x;
  logic        flick1, flick2;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        running;
  logic [1:0]  fsm_state;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  obstacle_spawner #(
    .BASE_SPEED(BASE_SPEED), .MAX_SPEED(MAX_SPEED), .SPEEDUP_EVERY(SPEEDUP_EVERY),
    .MIN_GAP(MIN_GAP), .FLICK_FRAMES(FLICK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .game_over(game_over),
    .obs1_type(obs1_type), .obs2_type(obs2_type), .obs1_pos(obs1_pos), .obs2_pos(obs2_pos),
    .obs1_x(obs1_x), .obs2_x(obs2_x), .flick1(flick1), .flick2(flick2),
    .speed(speed), .score(score), .running(running), .fsm_state(fsm_state)
  );

  // ---------------- reference model (frame level) ----------------
  // Game state: 0 ready, 1 run, 2 halt. Speed and score derive from the total
  // retirement count; flicker derives from the slot's age in frames.
  int m_state, m_lfsr, m_gap, m_retired, m_sp, m_tgt;
  bit m_act[2];
  int m_type[2], m_pos[2], m_x[2], m_age[2];
  bit m_was[2];
  bit model_valid = 1'b0;

  function automatic int lfsr_next(input int v);
    return (v >> 1) ^ (((v & 1) != 0) ? 32'h0000B400 : 32'h0);
  endfunction

  function automatic int model_speed(input int retired);
    int s;
    s = BASE_SPEED + retired / SPEEDUP_EVERY;
    return (s > MAX_SPEED) ? MAX_SPEED : s;
  endfunction

  task automatic m_park(input int i);
    m_act[i] = 1'b0; m_type[i] = 0; m_pos[i] = 0; m_x[i] = 840; m_age[i] = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_lfsr = 32'hACE1; m_gap = 0; m_retired = 0;
      m_park(0); m_park(1);
      model_valid = 1'b1;
    end else begin
      if (m_state == 0) begin
        if (start) begin
          m_state = 1;
          m_gap = MIN_GAP + ((m_lfsr >> 4) & 63);
        end
      end else if (m_state == 1) begin
        if (game_over) m_state = 2;
        else if (frame_tick) begin
          m_sp = model_speed(m_retired);
          m_was[0] = m_act[0]; m_was[1] = m_act[1];
          for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
              if (m_x[i] < m_sp) begin
                m_park(i);
                m_retired++;
              end else begin
                m_x[i] -= m_sp;
                m_age[i]++;
              end
            end
          end
          if (m_gap == 0 && !(m_was[0] && m_was[1])) begin
            m_tgt = m_was[0] ? 1 : 0;
            m_act[m_tgt]  = 1'b1;
            m_x[m_tgt]    = 740;
            m_type[m_tgt] = m_lfsr & 3;
            m_pos[m_tgt]  = (((m_lfsr >> 2) & 3) == 3) ? 1 : ((m_lfsr >> 2) & 3);
            m_age[m_tgt]  = 0;
            m_gap = MIN_GAP + ((m_lfsr >> 4) & 63);
          end else if (m_gap > 0) begin
            m_gap--;
          end
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  logic [63:0] got_v, exp_v;
  always @(negedge clk) begin
    if (!reset && model_valid) begin
      got_v = {obs1_type, obs2_type, obs1_pos, obs2_pos, obs1_x, obs2_x, flick1, flick2,
               speed, score, running, fsm_state, 8'd0};
      exp_v = {2'(m_type[0]), 2'(m_type[1]), 2'(m_pos[0]), 2'(m_pos[1]),
               10'(m_x[0]), 10'(m_x[1]),
               1'(m_act[0] ? (m_age[0] / FLICK_FRAMES) % 2 : 0),
               1'(m_act[1] ? (m_age[1] / FLICK_FRAMES) % 2 : 0),
               4'(model_speed(m_retired)), 16'(m_retired), (m_state == 1), 2'(m_state), 8'd0};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        if (fails < 20)
          $display("FAIL model_cmp t=%0t got x1=%0d x2=%0d t1=%0d t2=%0d p1=%0d p2=%0d f=%b%b sp=%0d sc=%0d run=%b st=%0d | exp x1=%0d x2=%0d t1=%0d t2=%0d p1=%0d p2=%0d sp=%0d sc=%0d st=%0d",
                   $time, obs1_x, obs2_x, obs1_type, obs2_type, obs1_pos, obs2_pos, flick1, flick2,
                   speed, score, running, fsm_state, m_x[0], m_x[1], m_type[0], m_type[1],
                   m_pos[0], m_pos[1], model_speed(m_retired), m_retired % 65536, m_state);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; frame_tick = 0; start = 0; game_over = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // One frame: strobe inputs for a cycle, then one idle cycle.
  task automatic tick(input bit go, input bit st);
    @(posedge clk); #1 frame_tick = 1'b1; game_over = go; start = st;
    @(posedge clk); #1 frame_tick = 1'b0; game_over = 1'b0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int n;
  bit found;
  int prev_score;

  initial begin
    do_reset();
    chk("reset_x1", obs1_x, 840);
    chk("reset_x2", obs2_x, 840);
    chk("reset_speed", speed, 4);
    chk("reset_score", score, 0);
    chk("reset_running", running, 0);
    chk("reset_flick1", flick1, 0);

    // Frames without start change nothing.
    repeat (10) tick(1'b0, 1'b0);
    chk("ready_x1", obs1_x, 840);
    chk("ready_x2", obs2_x, 840);
    chk("ready_score", score, 0);
    chk("ready_running", running, 0);

    // start coincident with a frame_tick: enters RUN, tick not processed.
    tick(1'b0, 1'b1);
    chk("start_running", running, 1);
    chk("start_x1", obs1_x, 840);

    found = 1'b0; n = 0;
    while (!found && n < 120) begin
      tick(1'b0, 1'b0); n++;
      if (obs1_x == 740) found = 1'b1;
    end
    chk("first_spawn_seen", found, 1);
    chk("first_spawn_delay_in_range", (n >= MIN_GAP + 1 && n <= MIN_GAP + 64), 1);
    chk("spawn_flick", flick1, 0);
    chk("spawn_x2_parked", obs2_x, 840);

    for (int k = 1; k <= 24; k++) begin
      tick(1'b0, 1'b0);
      if (k == 1)  chk("scroll_x1_736", obs1_x, 736);
      if (k == 7)  chk("flick_t7", flick1, 0);
      if (k == 8)  chk("flick_t8", flick1, 1);
      if (k == 16) chk("flick_t16", flick1, 0);
      if (k == 24) begin
        chk("flick_t24", flick1, 1);
        chk("x1_t24", obs1_x, 644);
        chk("x2_t24_parked", obs2_x, 840);
      end
    end

    // Scroll obs1 down to x=0, then it must retire on the next frame.
    n = 0;
    while (obs1_x != 0 && n < 200) begin tick(1'b0, 1'b0); n++; end
    chk("x1_reaches_0", obs1_x, 0);
    tick(1'b0, 1'b0);
    chk("retire_x1", obs1_x, 840);
    chk("retire_flick1", flick1, 0);
    chk("retire_pos1", obs1_pos, 0);
    chk("retire_score", score, 1);

    // Eighth retirement raises speed to 5.
    n = 0; prev_score = score;
    while (score < 8 && n < 3000) begin tick(1'b0, 1'b0); n++; end
    chk("score_reached_8", (score >= 8), 1);
    chk("speed_after_8", speed, 5);

    // Speed saturates at MAX_SPEED.
    n = 0;
    while (speed < MAX_SPEED && n < 10000) begin tick(1'b0, 1'b0); n++; end
    chk("speed_reaches_max", speed, 12);
    repeat (200) tick(1'b0, 1'b0);
    chk("speed_capped", speed, 12);
    chk("score_ge_64", (score >= 64), 1);

    // Collision on a frame_tick: HALT and freeze, start ignored.
    tick(1'b1, 1'b0);
    chk("halt_running", running, 0);
    chk("halt_state", fsm_state, 2);
    repeat (100) tick(1'b0, 1'b1);
    chk("halt_still_running0", running, 0);
    chk("halt_still_state", fsm_state, 2);

    do_reset();
    chk("rereset_x1", obs1_x, 840);
    chk("rereset_x2", obs2_x, 840);
    chk("rereset_score", score, 0);
    chk("rereset_speed", speed, 4);
    chk("rereset_state", fsm_state, 0);

    // Random start timing; the per-cycle model comparison covers content.
    repeat (6) begin
      do_reset();
      idle($urandom_range(0, 50));
      pulse_start();
      repeat (250) tick(1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the sequence is bounded, but never let a broken DUT hang the run.
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Generates and scrolls the two obstacle slots consumed by the pixel animator. It drives per-slot type, vertical position band, x position and flicker phase, and advances one step per video frame. Randomness comes from an LFSR. It freezes the field when the animator raises game_over and counts cleared obstacles as the score.

## Interface
- BASE_SPEED, 4, initial scroll step in px/frame
- MAX_SPEED, 12, speed ceiling
- SPEEDUP_EVERY, 8, retirements per +1 speed
- MIN_GAP, 40, minimum frames between spawns
- FLICK_FRAMES, 8, frames per flicker half-period
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (end of visible area)
- start  in  1  one-cycle pulse; begins play from READY
- game_over  in  1  collision flag from animator (level, combinational)
- obs1_type, obs2_type  out  2  00 flat, 01 tall, 10 falling tri, 11 rising tri
- obs1_pos, obs2_pos  out  2  00 top, 01 middle, 10 bottom; 11 never driven
- obs1_x, obs2_x  out  10  biased x (screen x + 100)
- flick1, flick2  out  1  flicker phase
- speed  out  4  current scroll step
- score  out  16  obstacles retired since reset
- running  out  1  high in RUN

## Operation
- FSM: READY -> RUN on start; RUN -> HALT when game_over is sampled high; HALT holds until reset; reset from any state returns to READY.
- Slot state: active bit, type, pos, x, flick, flick counter.
- Parked slot: x = PARK_X (840), type 00, pos 00, flick 0. This renders fully off-screen right.
- LFSR: 16-bit Galois, mask 0xB400, seed 0xACE1. It steps every clk in all states, so spawn content depends on start timing.
- Gap counter: loaded with MIN_GAP + lfsr[9:4] (0..63) on the READY->RUN transition and after every spawn. It decrements on frame_tick in RUN and saturates at 0.
- Spawn, evaluated on frame_tick in RUN:
  - Condition: gap == 0 and at least one slot is inactive at the start of that tick.
  - Target is the lowest-numbered inactive slot.
  - x = SPAWN_X (740), type = lfsr[1:0], pos = lfsr[3:2] with 11 remapped to 01, flick counter cleared, flick 0.
  - If both slots are active, the spawn is deferred with gap held at 0.
  - A slot freed on a tick is not reusable until the next tick.
- Scroll, on frame_tick in RUN, each active slot:
  - If x < speed: retire the slot (park it, clear active), score +1 with 16-bit wrap.
  - Otherwise x <= x - speed.
  - A slot spawned on this tick is not scrolled on the same tick.
- Speed: starts at BASE_SPEED. After every SPEEDUP_EVERY retirements, speed +1, saturating at MAX_SPEED.
  - Two retirements on one tick count as 2.
  - Speed takes effect on the following tick.
- Flicker: per active slot, the counter increments on frame_tick; flick toggles at FLICK_FRAMES and the counter clears.
- READY and HALT: no spawn, scroll, flicker, score or speed change. HALT keeps the last outputs so the animator can draw the crash frame.

## Timing
- All outputs are registered. Updates appear the clk after the frame_tick edge; latency is 1 cycle.
- Reset values:
  - obs*_x = 840, obs*_type = 00, obs*_pos = 00, flick* = 0.
  - speed = BASE_SPEED, score = 0, running = 0, gap = 0.
  - LFSR = 0xACE1.
- game_over takes priority: if game_over and frame_tick are high in the same cycle, the FSM enters HALT and no slot moves.
- start is ignored outside READY. start and frame_tick in the same cycle: the FSM enters RUN and that tick is not processed.
- Arithmetic: x subtraction in 10 bits, guarded by the x < speed compare, so there is no underflow. Gap arithmetic is 7-bit.

## Structure
- obstacle_pkg holds:
  - obs_type_t, obs_pos_t and state_t enums
  - PARK_X, SPAWN_X, LFSR_SEED, LFSR_MASK
- Sub-module lfsr16: clk, reset, q[15:0], free-running.
- The top instantiates lfsr16, the FSM, one gap counter, and two identical slot registers, built with a generate loop or a per-slot always_ff.

## Test plan
- Reset, then 10 frame_ticks with no start -> both x = 840, score 0, running 0, outputs unchanged.
- start, then ticks -> first spawn within MIN_GAP..MIN_GAP+63 ticks: obs1_x = 740. Next tick -> 736. obs2 stays at 840 until the next gap expires.
- 2000 spawns with random start timing -> obs*_pos never 11. Every active slot's x decreases by exactly speed per tick.
- Slot at x = 3, speed 4, frame_tick -> x = 840, score +1. On the 8th retirement -> speed 5. Continued play -> speed caps at 12.
- game_over and frame_tick in the same cycle -> running 0, all outputs frozen for 100 ticks, start ignored. Reset -> READY values.
- Active slot, FLICK_FRAMES = 8 -> flick toggles on ticks 8, 16, 24 after spawn. After retirement, flick = 0.
